// File: rtl/alu_seq_n.sv
// Registered W-bit ALU: single-cycle logic/shift ops, iterative MULU/DIVU with Start/Busy/Done.
// Single-cycle ops pulse Done the cycle after capture; MULU/DIVU pulse Done W cycles after capture.
module alu_seq_n #(
  parameter int W = 32
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         Start,
  input  logic [3:0]   Op,
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  output logic         Busy,
  output logic         Done,
  output logic [W-1:0] Result,
  output logic [W-1:0] ResultHi,
  output logic         ZF,
  output logic         CF,
  output logic         OF,
  output logic         NF,
  output logic         DivZero
);

  localparam int SHW = $clog2(W);
  localparam int CW  = $clog2(W) + 1;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                         OP_XOR = 4'd4, OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7,
                         OP_ASR = 4'd8, OP_ROL = 4'd9, OP_ROR = 4'd10, OP_MULU = 4'd11,
                         OP_DIVU = 4'd12;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t         state;
  logic [W-1:0]   hi, lo, opnd;
  logic [CW-1:0]  count;

  logic [SHW-1:0] amt;
  logic [SHW:0]   inv_amt;
  logic [W:0]     sum;
  logic [W-1:0]   alu_res;
  logic           alu_cf, alu_of;

  always_comb begin
    amt     = Y[SHW-1:0];
    inv_amt = (SHW+1)'(W) - {1'b0, amt};
    sum     = '0;
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    case (Op)
      OP_ADD: begin
        sum     = {1'b0, X} + {1'b0, Y};
        alu_res = sum[W-1:0];
        alu_cf  = sum[W];
        alu_of  = (X[W-1] == Y[W-1]) && (sum[W-1] != X[W-1]);
      end
      OP_SUB: begin
        sum     = {1'b0, X} + {1'b0, ~Y} + (W+1)'(1);
        alu_res = sum[W-1:0];
        alu_cf  = sum[W];
        alu_of  = (X[W-1] != Y[W-1]) && (sum[W-1] != X[W-1]);
      end
      OP_AND:  alu_res = X & Y;
      OP_OR:   alu_res = X | Y;
      OP_XOR:  alu_res = X ^ Y;
      OP_NOT:  alu_res = ~X;
      OP_SHL:  alu_res = X << amt;
      OP_SHR:  alu_res = X >> amt;
      OP_ASR:  alu_res = $signed(X) >>> amt;
      OP_ROL:  alu_res = (X << amt) | (X >> inv_amt);
      OP_ROR:  alu_res = (X >> amt) | (X << inv_amt);
      default: alu_res = '0;
    endcase
  end

  // The first iteration runs on the capture edge straight from X/Y, so W edges finish the op.
  logic         is_mul;
  logic [W-1:0] cur_hi, cur_lo, cur_opnd;
  logic [W:0]   madd, dshift, ddiff;
  logic [W-1:0] step_hi, step_lo;

  always_comb begin
    is_mul   = (state == MUL) || (state == IDLE && Op == OP_MULU);
    cur_hi   = (state == IDLE) ? '0 : hi;
    cur_lo   = (state == IDLE) ? (is_mul ? Y : X) : lo;
    cur_opnd = (state == IDLE) ? (is_mul ? X : Y) : opnd;
    madd     = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_opnd} : '0);
    dshift   = {cur_hi, cur_lo[W-1]};
    ddiff    = dshift - {1'b0, cur_opnd};
    if (is_mul) begin
      step_hi = madd[W:1];
      step_lo = {madd[0], cur_lo[W-1:1]};
    end else begin
      step_hi = ddiff[W] ? dshift[W-1:0] : ddiff[W-1:0];
      step_lo = {cur_lo[W-2:0], ~ddiff[W]};
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= IDLE;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      count    <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Result   <= '0;
      ResultHi <= '0;
      ZF       <= 1'b0;
      CF       <= 1'b0;
      OF       <= 1'b0;
      NF       <= 1'b0;
      DivZero  <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (Op == OP_MULU || (Op == OP_DIVU && Y != '0)) begin
              hi    <= step_hi;
              lo    <= step_lo;
              opnd  <= (Op == OP_MULU) ? X : Y;
              count <= CW'(W - 1);
              state <= (Op == OP_MULU) ? MUL : DIV;
              Busy  <= 1'b1;
            end else if (Op == OP_DIVU) begin
              Result   <= '1;
              ResultHi <= X;
              ZF       <= 1'b0;
              NF       <= 1'b1;
              CF       <= 1'b0;
              OF       <= 1'b0;
              DivZero  <= 1'b1;
              Done     <= 1'b1;
            end else begin
              Result   <= alu_res;
              ResultHi <= '0;
              ZF       <= (alu_res == '0);
              NF       <= alu_res[W-1];
              CF       <= alu_cf;
              OF       <= alu_of;
              DivZero  <= 1'b0;
              Done     <= 1'b1;
            end
          end
        end
        MUL, DIV: begin
          hi    <= step_hi;
          lo    <= step_lo;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            Result   <= step_lo;
            ResultHi <= step_hi;
            ZF       <= (step_lo == '0);
            NF       <= step_lo[W-1];
            CF       <= is_mul && (step_hi != '0);
            OF       <= is_mul && (step_hi != '0);
            DivZero  <= 1'b0;
            Done     <= 1'b1;
            Busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_n.sv
// Bench for alu_seq_n: W=8 directed table plus multi-cycle sequences, and a W=32 model-checked chain.
module tb_alu_seq_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start;
  logic [3:0] op;
  logic [7:0] x, y, res, res_hi;
  logic       busy, done, zf, cf, of, nf, dz;

  logic        start32;
  logic [3:0]  op32;
  logic [31:0] x32, y32, res32, res_hi32;
  logic        busy32, done32, zf32, cf32, of32, nf32, dz32;

  alu_seq_n #(.W(8)) dut8 (
    .Clock(clk), .Resetn(rst_n), .Start(start), .Op(op), .X(x), .Y(y),
    .Busy(busy), .Done(done), .Result(res), .ResultHi(res_hi),
    .ZF(zf), .CF(cf), .OF(of), .NF(nf), .DivZero(dz)
  );

  alu_seq_n #(.W(32)) dut32 (
    .Clock(clk), .Resetn(rst_n), .Start(start32), .Op(op32), .X(x32), .Y(y32),
    .Busy(busy32), .Done(done32), .Result(res32), .ResultHi(res_hi32),
    .ZF(zf32), .CF(cf32), .OF(of32), .NF(nf32), .DivZero(dz32)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // flags packed as {ZF,CF,OF,NF,DivZero}
  typedef struct {
    logic [3:0] op;
    logic [7:0] x, y, r, rh;
    logic [4:0] fl;
    int         lat;
  } vec_t;

  vec_t tbl[23];

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  // Returns at the negedge on which Done is seen; operands are scrambled after capture.
  task automatic do_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                       output int lat);
    @(negedge clk);
    start = 1'b1; op = o; x = a; y = b;
    @(negedge clk);
    start = 1'b0; op = ~o; x = ~a; y = ~b;
    wait_done(lat);
  endtask

  function automatic void ref32(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [31:0] rh,
                                output logic [4:0] fl, output int lat);
    logic [32:0] s;
    logic [63:0] p;
    int          sh;
    logic        c, v, d;
    sh = int'(b[4:0]);
    r = '0; rh = '0; c = 1'b0; v = 1'b0; d = 1'b0; lat = 1;
    case (o)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                  v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[31:0]; c = (a >= b);
                  v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = a << sh;
      4'd7: r = a >> sh;
      4'd8: r = $signed(a) >>> sh;
      4'd9: r = (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
      4'd10: r = (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
      4'd11: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; rh = p[63:32];
                   c = (rh != 0); v = c; lat = 32; end
      4'd12: begin
        if (b == 0) begin r = '1; rh = a; d = 1'b1; end
        else begin r = a / b; rh = a % b; lat = 32; end
      end
      default: r = '0;
    endcase
    fl = {r == 0, c, v, r[31], d};
  endfunction

  initial begin
    int lat;
    logic [7:0] busy_seq, done_seq;
    logic [31:0] er, erh;
    logic [4:0]  efl;
    int          elat;

    tbl[0]  = '{4'd0,  8'h7F, 8'h01, 8'h80, 8'h00, 5'b00110, 1};
    tbl[1]  = '{4'd1,  8'h05, 8'h05, 8'h00, 8'h00, 5'b11000, 1};
    tbl[2]  = '{4'd1,  8'h00, 8'h01, 8'hFF, 8'h00, 5'b00010, 1};
    tbl[3]  = '{4'd2,  8'hF0, 8'h3C, 8'h30, 8'h00, 5'b00000, 1};
    tbl[4]  = '{4'd3,  8'hF0, 8'h0C, 8'hFC, 8'h00, 5'b00010, 1};
    tbl[5]  = '{4'd4,  8'hAA, 8'hAA, 8'h00, 8'h00, 5'b10000, 1};
    tbl[6]  = '{4'd5,  8'h0F, 8'h55, 8'hF0, 8'h00, 5'b00010, 1};
    tbl[7]  = '{4'd6,  8'h81, 8'h00, 8'h81, 8'h00, 5'b00010, 1};
    tbl[8]  = '{4'd6,  8'h81, 8'h0B, 8'h08, 8'h00, 5'b00000, 1};
    tbl[9]  = '{4'd7,  8'h81, 8'h03, 8'h10, 8'h00, 5'b00000, 1};
    tbl[10] = '{4'd8,  8'h80, 8'h03, 8'hF0, 8'h00, 5'b00010, 1};
    tbl[11] = '{4'd9,  8'h81, 8'h01, 8'h03, 8'h00, 5'b00000, 1};
    tbl[12] = '{4'd10, 8'h81, 8'h09, 8'hC0, 8'h00, 5'b00010, 1};
    tbl[13] = '{4'd13, 8'hFF, 8'hFF, 8'h00, 8'h00, 5'b10000, 1};
    tbl[14] = '{4'd0,  8'hFF, 8'h01, 8'h00, 8'h00, 5'b11000, 1};
    tbl[15] = '{4'd1,  8'h80, 8'h01, 8'h7F, 8'h00, 5'b01100, 1};
    tbl[16] = '{4'd11, 8'hFF, 8'hFF, 8'h01, 8'hFE, 5'b01100, 8};
    tbl[17] = '{4'd11, 8'h0F, 8'h03, 8'h2D, 8'h00, 5'b00000, 8};
    tbl[18] = '{4'd12, 8'h64, 8'h07, 8'h0E, 8'h02, 5'b00000, 8};
    tbl[19] = '{4'd12, 8'h2A, 8'h00, 8'hFF, 8'h2A, 5'b00011, 1};
    tbl[20] = '{4'd12, 8'h05, 8'h09, 8'h00, 8'h05, 5'b10000, 8};
    tbl[21] = '{4'd8,  8'h40, 8'h02, 8'h10, 8'h00, 5'b00000, 1};
    tbl[22] = '{4'd15, 8'h12, 8'h34, 8'h00, 8'h00, 5'b10000, 1};

    rst_n = 1'b0; start = 1'b0; op = '0; x = '0; y = '0;
    start32 = 1'b0; op32 = '0; x32 = '0; y32 = '0;
    repeat (2) @(negedge clk);
    chk("reset outputs", {busy, done, res, res_hi, zf, cf, of, nf, dz}, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      do_op(tbl[i].op, tbl[i].x, tbl[i].y, lat);
      chk($sformatf("vec%0d latency", i), lat, tbl[i].lat);
      chk($sformatf("vec%0d result", i), res, tbl[i].r);
      chk($sformatf("vec%0d result_hi", i), res_hi, tbl[i].rh);
      chk($sformatf("vec%0d flags", i), {zf, cf, of, nf, dz}, tbl[i].fl);
    end

    // MULU busy window, Start ignored while busy, single Done pulse
    @(negedge clk);
    start = 1'b1; op = 4'd11; x = 8'hFF; y = 8'hFF;
    @(negedge clk);
    start = 1'b0; x = 8'h00; y = 8'h00;
    busy_seq = '0; done_seq = '0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clk);
      busy_seq[c-1] = busy;
      done_seq[c-1] = done;
      if (c == 3) begin start = 1'b1; op = 4'd0; x = 8'h01; y = 8'h01; end
      else start = 1'b0;
    end
    chk("mulu busy window", busy_seq, 8'h7F);
    chk("mulu done cycle", done_seq, 8'h80);
    chk("mulu seq result", {res_hi, res}, 16'hFE01);
    @(negedge clk);
    chk("no second done", {done, busy}, 2'b00);
    chk("result holds", {res_hi, res}, 16'hFE01);

    // back-to-back: ADD issued on the DIVU Done cycle
    @(negedge clk);
    start = 1'b1; op = 4'd12; x = 8'h64; y = 8'h07;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("b2b divu latency", lat, 8);
    start = 1'b1; op = 4'd0; x = 8'h03; y = 8'h04;
    @(negedge clk);
    start = 1'b0;
    chk("b2b add done", done, 1'b1);
    chk("b2b add result", {res_hi, res, dz}, {8'h00, 8'h07, 1'b0});

    // reset in the middle of MULU aborts without Done
    @(negedge clk);
    start = 1'b1; op = 4'd11; x = 8'hFF; y = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort outputs", {busy, done, res, res_hi, zf, cf, of, nf, dz}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort no done", {busy, done}, 2'b00);
    do_op(4'd0, 8'h01, 8'h01, lat);
    chk("post-reset add latency", lat, 1);
    chk("post-reset add result", res, 8'h02);

    // W=32 chained regression, each Start issued on the previous Done cycle
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      logic [3:0]  o;
      logic [31:0] a, b;
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if (o == 4'd12 && $urandom_range(0, 3) == 0) b = '0;
      if (i == 0) begin o = 4'd11; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
      ref32(o, a, b, er, erh, efl, elat);
      start32 = 1'b1; op32 = o; x32 = a; y32 = b;
      @(negedge clk);
      start32 = 1'b0; x32 = $urandom; y32 = $urandom;
      lat = 1;
      while (!done32 && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      chk($sformatf("w32 op%0d #%0d latency", o, i), lat, elat);
      chk($sformatf("w32 op%0d #%0d result", o, i), {res_hi32, res32}, {erh, er});
      chk($sformatf("w32 op%0d #%0d flags", o, i), {zf32, cf32, of32, nf32, dz32}, efl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
